// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: accepts a held load/store request, stalls the
// pipeline for LAT cycles, then pulses done. Optional macro: DMEM_ALIGN_CHECK_EN.
module dmem_responder #(
  parameter int ADDR_W = 8,
  parameter int LAT    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_rd,
  input  logic        req_wr,
  input  logic [15:0] addr,
  input  logic [15:0] wr_data,
  output logic [15:0] rd_data,
  output logic        stall,
  output logic        done,
  output logic        err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state_r;
  logic [3:0]          count_r;
  logic                op_wr_r;
  logic [ADDR_W-1:0]   idx_r;
  logic [15:0]         wdata_r;
  logic [15:0]         rd_data_r;
  logic                done_r;
  logic [15:0]         mem_r [0:(1<<ADDR_W)-1];
  logic                illegal_s;
  logic                legal_s;
  logic                unused_s;

  // Address bits above the word index alias; addr[0] only matters with the alignment check.
  assign unused_s = ^{addr[15:ADDR_W+1], addr[0]};

  // Request qualification, evaluated only while idle.
  always_comb begin
    illegal_s = 1'b0;
    legal_s   = 1'b0;
    if (state_r == IDLE) begin
`ifdef DMEM_ALIGN_CHECK_EN
      illegal_s = (req_rd & req_wr) | ((req_rd | req_wr) & addr[0]);
`else
      illegal_s = req_rd & req_wr;
`endif
      legal_s = (req_rd | req_wr) & ~illegal_s;
    end else begin
      illegal_s = 1'b0;
      legal_s   = 1'b0;
    end
  end

  // stall rises in the acceptance cycle itself so the upstream stage freezes at once.
  assign stall   = (state_r == BUSY) | legal_s;
  assign err     = illegal_s;
  assign done    = done_r;
  assign rd_data = rd_data_r;

  // Access sequencing: latch request, count down, then one-cycle completion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      count_r   <= 4'd0;
      op_wr_r   <= 1'b0;
      idx_r     <= '0;
      wdata_r   <= 16'h0000;
      rd_data_r <= 16'h0000;
      done_r    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          if (legal_s) begin
            op_wr_r <= req_wr;
            idx_r   <= addr[ADDR_W:1];
            wdata_r <= wr_data;
            count_r <= 4'(LAT - 2);
            state_r <= BUSY;
          end
        end
        BUSY: begin
          if (count_r == 4'd0) begin
            state_r <= DONE;
            done_r  <= 1'b1;
            if (!op_wr_r) begin
              rd_data_r <= mem_r[idx_r];
            end
          end else begin
            count_r <= count_r - 4'd1;
          end
        end
        DONE: begin
          done_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          done_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  // Store commit on the edge that closes DONE; a reset during the access leaves the array untouched.
  always_ff @(posedge clk) begin
    if (!rst && (state_r == DONE) && op_wr_r) begin
      mem_r[idx_r] <= wdata_r;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one LAT=4 instance and one LAT=2 instance,
// expected values hand-computed from the intended cycle behaviour.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rd_a = 1'b0, wr_a = 1'b0, rd_b = 1'b0, wr_b = 1'b0;
  logic [15:0] addr_a = 16'h0000, wdata_a = 16'h0000, addr_b = 16'h0000, wdata_b = 16'h0000;
  logic [15:0] rdata_a, rdata_b;
  logic        stall_a, done_a, err_a, stall_b, done_b, err_b;
  logic [15:0] o_rd;
  logic        o_stall, o_done, o_err;
  int          sel = 0;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  dmem_responder #(.ADDR_W(8), .LAT(4)) dut_a (
    .clk(clk), .rst(rst), .req_rd(rd_a), .req_wr(wr_a), .addr(addr_a), .wr_data(wdata_a),
    .rd_data(rdata_a), .stall(stall_a), .done(done_a), .err(err_a)
  );

  dmem_responder #(.ADDR_W(8), .LAT(2)) dut_b (
    .clk(clk), .rst(rst), .req_rd(rd_b), .req_wr(wr_b), .addr(addr_b), .wr_data(wdata_b),
    .rd_data(rdata_b), .stall(stall_b), .done(done_b), .err(err_b)
  );

  always_comb begin
    o_rd    = (sel == 0) ? rdata_a : rdata_b;
    o_stall = (sel == 0) ? stall_a : stall_b;
    o_done  = (sel == 0) ? done_a  : done_b;
    o_err   = (sel == 0) ? err_a   : err_b;
  end

  task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [15:0] a, input logic [15:0] d);
    if (sel == 0) begin
      rd_a = rd; wr_a = wr; addr_a = a; wdata_a = d;
    end else begin
      rd_b = rd; wr_b = wr; addr_b = a; wdata_b = d;
    end
  endtask

  // Request held for cycles 0..lat; stall expected 0..lat-1, done at lat.
  task automatic run_req(input string tag, input logic wr, input logic [15:0] a,
                         input logic [15:0] d, input int lat, input logic [15:0] exp_rd);
    for (int c = 0; c <= lat; c++) begin
      @(negedge clk);
      if (c == 0) drive(~wr, wr, a, d);
      #1;
      if (c < lat) begin
        check_val({tag, "_stall"}, {15'd0, o_stall}, 16'd1);
        check_val({tag, "_done0"}, {15'd0, o_done}, 16'd0);
      end else begin
        check_val({tag, "_done"}, {15'd0, o_done}, 16'd1);
        check_val({tag, "_stall0"}, {15'd0, o_stall}, 16'd0);
        check_val({tag, "_rd"}, o_rd, exp_rd);
      end
    end
  endtask

  task automatic idle_cycles(input string tag, input int n, input logic [15:0] exp_rd);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (i == 0) drive(1'b0, 1'b0, 16'h0000, 16'h0000);
      #1;
      check_val({tag, "_idle_stall"}, {15'd0, o_stall}, 16'd0);
      check_val({tag, "_idle_done"}, {15'd0, o_done}, 16'd0);
      check_val({tag, "_idle_err"}, {15'd0, o_err}, 16'd0);
      check_val({tag, "_idle_rd"}, o_rd, exp_rd);
    end
  endtask

  task automatic run_err(input string tag, input logic rd, input logic wr, input logic [15:0] a,
                         input logic [15:0] d, input int n, input logic [15:0] exp_rd);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      if (c == 0) drive(rd, wr, a, d);
      #1;
      check_val({tag, "_err"}, {15'd0, o_err}, 16'd1);
      check_val({tag, "_stall0"}, {15'd0, o_stall}, 16'd0);
      check_val({tag, "_done0"}, {15'd0, o_done}, 16'd0);
      check_val({tag, "_rd"}, o_rd, exp_rd);
    end
  endtask

  initial begin
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_val("rst_stall", {15'd0, stall_a}, 16'd0);
    check_val("rst_done", {15'd0, done_a}, 16'd0);
    check_val("rst_err", {15'd0, err_a}, 16'd0);
    check_val("rst_rd_a", rdata_a, 16'h0000);
    check_val("rst_rd_b", rdata_b, 16'h0000);

    sel = 0;
    run_req("st10", 1'b1, 16'h0010, 16'hBEEF, 4, 16'h0000);
    idle_cycles("st10", 1, 16'h0000);
    run_req("ld10", 1'b0, 16'h0010, 16'h0000, 4, 16'hBEEF);
    idle_cycles("ld10", 3, 16'hBEEF);

    run_err("both", 1'b1, 1'b1, 16'h0010, 16'hDEAD, 3, 16'hBEEF);
    idle_cycles("both", 1, 16'hBEEF);
    run_req("ld10b", 1'b0, 16'h0010, 16'h0000, 4, 16'hBEEF);
    idle_cycles("ld10b", 1, 16'hBEEF);

`ifdef DMEM_ALIGN_CHECK_EN
    run_err("unal", 1'b1, 1'b0, 16'h0011, 16'h0000, 3, 16'hBEEF);
`else
    run_req("unal", 1'b0, 16'h0011, 16'h0000, 4, 16'hBEEF);
`endif
    idle_cycles("unal", 1, 16'hBEEF);

    run_req("st_alias", 1'b1, 16'h0222, 16'h7777, 4, 16'hBEEF);
    idle_cycles("st_alias", 1, 16'hBEEF);
    run_req("ld_alias", 1'b0, 16'h0022, 16'h0000, 4, 16'h7777);
    idle_cycles("ld_alias", 1, 16'h7777);

    run_req("st20", 1'b1, 16'h0020, 16'h5555, 4, 16'h7777);
    idle_cycles("st20", 1, 16'h7777);
    @(negedge clk);
    drive(1'b0, 1'b1, 16'h0020, 16'h1234);
    #1;
    check_val("abort_c0_stall", {15'd0, stall_a}, 16'd1);
    @(negedge clk);
    #1;
    check_val("abort_c1_stall", {15'd0, stall_a}, 16'd1);
    @(negedge clk);
    rst = 1'b1;
    drive(1'b0, 1'b0, 16'h0000, 16'h0000);
    #1;
    check_val("abort_stall", {15'd0, stall_a}, 16'd0);
    check_val("abort_done", {15'd0, done_a}, 16'd0);
    check_val("abort_rd", rdata_a, 16'h0000);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_val("abort_post_stall", {15'd0, stall_a}, 16'd0);
    check_val("abort_post_done", {15'd0, done_a}, 16'd0);
    run_req("ld20", 1'b0, 16'h0020, 16'h0000, 4, 16'h5555);
    idle_cycles("ld20", 1, 16'h5555);

    sel = 1;
    run_req("b_st10", 1'b1, 16'h0010, 16'hA5A5, 2, 16'h0000);
    idle_cycles("b_st10", 1, 16'h0000);
    run_req("b_st12", 1'b1, 16'h0012, 16'h3C3C, 2, 16'h0000);
    idle_cycles("b_st12", 1, 16'h0000);
    run_req("b_ld10", 1'b0, 16'h0010, 16'h0000, 2, 16'hA5A5);
    run_req("b_ld12", 1'b0, 16'h0012, 16'h0000, 2, 16'h3C3C);
    idle_cycles("b_ld12", 2, 16'h3C3C);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
